// File: rtl/fsb8_target.sv
// FSB8 bus target: decodes multiplexed address/data cycles from the FSB8 initiator and
// replays each byte as a Wishbone master cycle, pacing the initiator through rdy_n.
module fsb8_target #(
  parameter int                ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(24'hC10000),
  parameter logic [ADDR_W-1:0] ADDR_MASK  = ADDR_W'(24'hFF0000),
  parameter int                WB_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ale_n,
  input  logic              cs_n,
  input  logic              cmd_n,
  input  logic              typ,
  input  logic              wr_n,
  input  logic [7:0]        ad_in,
  input  logic [7:0]        aah8,
  output logic [7:0]        ad_out,
  output logic              ad_oe,
  output logic              rdy_oe,
  input  logic              irq_req,
  output logic              irq_oe,
  output logic              bus_err,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [7:0]        wb_dat_o,
  input  logic [7:0]        wb_dat_i,
  output logic              wb_we,
  output logic              wb_cyc,
  output logic              wb_stb,
  input  logic              wb_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR2, S_WAIT_CS, S_WB, S_RDY, S_NEXT, S_WAIT_END, S_MISS
  } state_t;

  localparam bit        NEED_A2 = (ADDR_W != 16);
  localparam logic [3:0] TMO_LAST = 4'(WB_TIMEOUT - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cap1, cap2;
  logic              hit1, hit2;
  logic              we_q, typ_q, seen_cs;
  logic [3:0]        tmo_cnt;
  logic              tmo;
  state_t            cap_ns;

  // First address cycle supplies A[15:0]; the second (24/32-bit buses) supplies the rest.
  assign cap1 = ADDR_W'({aah8, ad_in});

  if (ADDR_W == 32) begin : g_a32
    assign cap2 = {aah8, ad_in, addr_q[15:0]};
  end else if (ADDR_W == 24) begin : g_a24
    assign cap2 = {ad_in, addr_q[15:0]};
  end else begin : g_a16
    assign cap2 = addr_q;
  end

  assign hit1   = ((cap1 ^ BASE_ADDR) & ADDR_MASK) == '0;
  assign hit2   = ((cap2 ^ BASE_ADDR) & ADDR_MASK) == '0;
  assign tmo    = (tmo_cnt == TMO_LAST);
  assign cap_ns = NEED_A2 ? S_ADDR2 : (hit1 ? S_WAIT_CS : S_MISS);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: defaulting state_nx first keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (!ale_n) state_nx = cap_ns;
      S_ADDR2:   if (!ale_n) state_nx = hit2 ? S_WAIT_CS : S_MISS;
                 else        state_nx = S_IDLE;
      S_WAIT_CS: if (!ale_n)     state_nx = cap_ns;
                 else if (!cs_n) state_nx = cmd_n ? S_WB : S_MISS;
      S_WB:      if (wb_ack || tmo) state_nx = S_RDY;
      S_RDY:     state_nx = typ_q ? S_NEXT : S_WAIT_END;
      S_NEXT:    state_nx = cs_n ? S_IDLE : S_WB;
      S_WAIT_END,
      S_MISS:    if (!ale_n)             state_nx = cap_ns;
                 else if (cs_n && seen_cs) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    wb_cyc = (state == S_WB);
    wb_stb = wb_cyc;
    wb_we  = wb_cyc & we_q;
    wb_adr = wb_cyc ? addr_q : '0;
    rdy_oe = (state == S_RDY);
    // The initiator owns AD8 whenever it signals an address cycle.
    ad_oe  = rdy_oe & ~we_q & ale_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      typ_q    <= 1'b0;
      seen_cs  <= 1'b0;
      tmo_cnt  <= '0;
      ad_out   <= 8'h00;
      wb_dat_o <= 8'h00;
      bus_err  <= 1'b0;
      irq_oe   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      irq_oe  <= irq_req;
      if (state != S_WB) tmo_cnt <= '0;
      seen_cs <= (state == S_RDY) || (state == S_WAIT_CS && !cs_n);

      case (state)
        S_IDLE:  if (!ale_n) addr_q <= cap1;
        S_ADDR2: if (!ale_n) addr_q <= cap2;
        S_WAIT_CS: begin
          if (!ale_n) begin
            addr_q <= cap1;
          end else if (!cs_n && cmd_n) begin
            we_q  <= ~wr_n;
            typ_q <= typ;
            if (!wr_n) wb_dat_o <= ad_in;
          end
        end
        S_WB: begin
          if (wb_ack) begin
            if (!we_q) ad_out <= wb_dat_i;
          end else if (tmo) begin
            ad_out  <= 8'hFF;
            bus_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        S_RDY:  if (typ_q) addr_q <= addr_q + ADDR_W'(1);
        S_NEXT: if (!cs_n && we_q) wb_dat_o <= ad_in;
        S_WAIT_END, S_MISS: begin
          // A data phase must be seen before its cs_n release can end the transfer.
          if (!ale_n) begin
            addr_q  <= cap1;
            seen_cs <= 1'b0;
          end else begin
            seen_cs <= seen_cs | ~cs_n;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fsb8_target.sv
// Directed bench for fsb8_target: single/burst transfers, decode miss, timeout, reset, irq.
module tb_fsb8_target;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ale_n = 1'b1, cs_n = 1'b1, cmd_n = 1'b1, typ = 1'b0, wr_n = 1'b1;
  logic [7:0]  ad_in = 8'h00, aah8 = 8'h00;
  logic [7:0]  ad_out;
  logic        ad_oe, rdy_oe, irq_oe, bus_err;
  logic        irq_req = 1'b0;
  logic [23:0] wb_adr;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i = 8'h00;
  logic        wb_we, wb_cyc, wb_stb;
  logic        wb_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  // Slave model and activity monitors, sampled on the falling edge.
  int          slv_waits = 0;
  logic [7:0]  slv_rdata = 8'h00;
  logic        ack_en = 1'b1;
  int          wcnt = 0;
  int          cyc_cnt = 0, rdy_cnt = 0, oe_cnt = 0;
  int          log_n = 0;
  logic [23:0] log_adr [32];
  logic [7:0]  log_dat [32];
  logic        log_we  [32];
  logic [7:0]  bdat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  fsb8_target dut (
    .clk(clk), .rst(rst), .ale_n(ale_n), .cs_n(cs_n), .cmd_n(cmd_n), .typ(typ),
    .wr_n(wr_n), .ad_in(ad_in), .aah8(aah8), .ad_out(ad_out), .ad_oe(ad_oe),
    .rdy_oe(rdy_oe), .irq_req(irq_req), .irq_oe(irq_oe), .bus_err(bus_err),
    .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wb_cyc) cyc_cnt++;
    if (rdy_oe) rdy_cnt++;
    if (ad_oe)  oe_cnt++;
    if (wb_cyc && wb_stb && ack_en) begin
      if (wcnt == slv_waits) begin
        wb_ack   = 1'b1;
        wb_dat_i = slv_rdata;
        if (log_n < 32) begin
          log_adr[log_n] = wb_adr;
          log_dat[log_n] = wb_dat_o;
          log_we[log_n]  = wb_we;
        end
        log_n++;
      end else begin
        wb_ack = 1'b0;
        wcnt++;
      end
    end else begin
      wb_ack = 1'b0;
      wcnt   = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic addr_phase(input logic [23:0] a);
    @(negedge clk);
    cs_n = 1'b1; ale_n = 1'b0; ad_in = a[7:0]; aah8 = a[15:8];
    @(negedge clk);
    ad_in = a[23:16]; aah8 = 8'h00;
    @(negedge clk);
    ale_n = 1'b1;
  endtask

  // Returns the number of falling edges until rdy_oe is seen, or 0 if the budget expires.
  task automatic wait_rdy(output int lat);
    bit done = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (rdy_oe) begin
        lat  = k;
        done = 1'b1;
      end
    end
  endtask

  initial begin
    int lat, b, c0, r0, o0;

    #1;
    check("rst_ad_out", ad_out, 8'h00);
    check("rst_ad_oe", ad_oe, 0);
    check("rst_rdy_oe", rdy_oe, 0);
    check("rst_irq_oe", irq_oe, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_wb_cyc", wb_cyc, 0);
    check("rst_wb_adr", wb_adr, 0);
    check("rst_wb_dat_o", wb_dat_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single write, zero-wait slave
    slv_waits = 0; b = log_n; o0 = oe_cnt;
    addr_phase(24'hC10042);
    cs_n = 1'b0; cmd_n = 1'b1; wr_n = 1'b0; typ = 1'b0; ad_in = 8'h5A;
    wait_rdy(lat);
    check("t1_latency", lat, 2);
    check("t1_ad_oe_at_rdy", ad_oe, 0);
    check("t1_log_adr", log_adr[b], 24'hC10042);
    check("t1_log_dat", log_dat[b], 8'h5A);
    check("t1_log_we", log_we[b], 1);
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    check("t1_rdy_one_cycle", rdy_oe, 0);
    repeat (3) @(negedge clk);
    check("t1_wb_count", log_n - b, 1);
    check("t1_no_ad_oe", oe_cnt - o0, 0);

    // 2: single read, three wait states
    slv_waits = 3; slv_rdata = 8'hA7; b = log_n;
    addr_phase(24'hC10010);
    cs_n = 1'b0; wr_n = 1'b1; typ = 1'b0;
    wait_rdy(lat);
    check("t2_latency", lat, 5);
    check("t2_ad_oe", ad_oe, 1);
    check("t2_ad_out", ad_out, 8'hA7);
    check("t2_log_adr", log_adr[b], 24'hC10010);
    check("t2_log_we", log_we[b], 0);
    @(negedge clk);
    cs_n = 1'b1;
    check("t2_rdy_off", rdy_oe, 0);
    check("t2_ad_oe_off", ad_oe, 0);
    repeat (3) @(negedge clk);

    // 3: four-byte block write crossing the low-16 boundary
    slv_waits = 0; b = log_n; r0 = rdy_cnt;
    addr_phase(24'hC1FFFE);
    cs_n = 1'b0; wr_n = 1'b0; typ = 1'b1; ad_in = bdat[0];
    for (int i = 0; i < 4; i++) begin
      wait_rdy(lat);
      check($sformatf("t3_rdy_%0d", i), (lat != 0), 1);
      if (i < 3) ad_in = bdat[i+1];
      else       cs_n = 1'b1;
    end
    wr_n = 1'b1; typ = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_wb_count", log_n - b, 4);
    check("t3_rdy_count", rdy_cnt - r0, 4);
    check("t3_adr0", log_adr[b],   24'hC1FFFE);
    check("t3_adr1", log_adr[b+1], 24'hC1FFFF);
    check("t3_adr2", log_adr[b+2], 24'hC20000);
    check("t3_adr3", log_adr[b+3], 24'hC20001);
    check("t3_dat2", log_dat[b+2], 8'h33);
    check("t3_dat3", log_dat[b+3], 8'h44);
    check("t3_idle_cyc", wb_cyc, 0);

    // 4: decode miss, then a command cycle on a hit address
    c0 = cyc_cnt; r0 = rdy_cnt; o0 = oe_cnt;
    addr_phase(24'h800000);
    cs_n = 1'b0; wr_n = 1'b1;
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    addr_phase(24'hC10000);
    cs_n = 1'b0; cmd_n = 1'b0;
    repeat (3) @(negedge clk);
    cs_n = 1'b1; cmd_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_no_wb", cyc_cnt - c0, 0);
    check("t4_no_rdy", rdy_cnt - r0, 0);
    check("t4_no_ad_oe", oe_cnt - o0, 0);

    // 4b: the target must be back in IDLE and serve a new write
    b = log_n;
    addr_phase(24'hC10001);
    cs_n = 1'b0; wr_n = 1'b0; ad_in = 8'h3C;
    wait_rdy(lat);
    check("t4_recover_lat", lat, 2);
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_recover_dat", log_dat[b], 8'h3C);

    // 5: read with no acknowledge -> timeout
    ack_en = 1'b0; c0 = cyc_cnt;
    addr_phase(24'hC10030);
    cs_n = 1'b0; wr_n = 1'b1;
    wait_rdy(lat);
    check("t5_latency", lat, 16);
    check("t5_bus_err", bus_err, 1);
    check("t5_ad_out", ad_out, 8'hFF);
    check("t5_ad_oe", ad_oe, 1);
    check("t5_cyc_cycles", cyc_cnt - c0, 15);
    @(negedge clk);
    cs_n = 1'b1;
    check("t5_bus_err_pulse", bus_err, 0);
    repeat (2) @(negedge clk);

    // 6: reset in the middle of a Wishbone cycle, then irq
    addr_phase(24'hC10020);
    cs_n = 1'b0; wr_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_in_wb", wb_cyc, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_cyc_async", wb_cyc, 0);
    check("t6_stb_async", wb_stb, 0);
    check("t6_ad_out", ad_out, 8'h00);
    check("t6_wb_dat_o", wb_dat_o, 8'h00);
    check("t6_rdy_oe", rdy_oe, 0);
    @(negedge clk);
    rst = 1'b0; cs_n = 1'b1; irq_req = 1'b1;
    check("t6_irq_before", irq_oe, 0);
    @(negedge clk);
    check("t6_irq_after", irq_oe, 1);
    irq_req = 1'b0;
    @(negedge clk);
    check("t6_irq_release", irq_oe, 0);
    ack_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
